pip_stage5: RTL
===============

Name: pip_stage5

Overview:
- Memory-access and MEM/WB stage of the 5-stage pipeline, fed directly by the EX/MEM register outputs.
- Issues loads and stores to a variable-latency data memory over a req/ack handshake.
- Stalls the upstream pipeline while an access is outstanding.
- Selects the writeback value (ALU result, load data, or link PC) and registers it as the MEM/WB pipeline register feeding the register file.

Parameters:
- DSIZE, 16, data and register width
- ASIZE, 4, register-file address width
- ISIZE, 16, PC width
- DAWIDTH, 8, data-memory address width
- TIMEOUT, 15, max cycles waiting for dmem_ack before abort (range 1..255)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- w_addr_in  in  ASIZE  destination register from EX/MEM
- w_data_in  in  DSIZE  ALU result; memory address for loads/stores
- rdata2_in  in  DSIZE  store data
- mem_write_in  in  1  store
- mem_read_in  in  1  load
- mem_to_reg_in  in  1  writeback selects load data
- wen_in  in  1  register write enable
- jal_in  in  1  writeback selects pc_in
- pc_in  in  ISIZE  link PC (already incremented upstream)
- dmem_req  out  1  memory request
- dmem_we  out  1  1=write, 0=read
- dmem_addr  out  DAWIDTH  memory address
- dmem_wdata  out  DSIZE  store data
- dmem_rdata  in  DSIZE  load data, valid when dmem_ack=1
- dmem_ack  in  1  one-cycle completion pulse
- stall  out  1  freeze PC/IF/ID/EX/EX-MEM registers this cycle
- wb_wen  out  1  registered register-file write enable
- wb_addr  out  ASIZE  registered write address
- wb_data  out  DSIZE  registered write data
- mem_err  out  1  sticky timeout flag

Behaviour:
- Reset (sync, rst=1 at clk edge): state=IDLE, wait counter=0, wb_wen=0, wb_addr=0, wb_data=0, mem_err=0. While rst=1, dmem_req=0 and stall=0 combinationally.
- memop = mem_read_in | mem_write_in.
- Store precedence: if both mem_read_in and mem_write_in are 1, the operation is a store and no load data is written back.
- dmem_addr = w_data_in[DAWIDTH-1:0]; upper bits ignored. dmem_wdata = rdata2_in. dmem_we = mem_write_in. All three are combinational from inputs.
- FSM states: IDLE, WAIT.
- IDLE, memop=0: dmem_req=0, stall=0; MEM/WB register loads next cycle (0 latency beyond the register).
- IDLE, memop=1: dmem_req=1.
  - dmem_ack=1 same cycle: stall=0, MEM/WB loads, stay IDLE.
  - Otherwise: stall=1, counter<=1, go WAIT.
- WAIT: dmem_req=1 and inputs are held stable by the stall.
  - dmem_ack=1: stall=0, MEM/WB loads, counter<=0, go IDLE.
  - Else, counter==TIMEOUT: mem_err<=1, stall=0, MEM/WB loads a bubble (wb_wen<=0), go IDLE. The instruction is dropped.
  - Else: stall=1, counter++.
- Bubble while stalled: any cycle with stall=1 loads wb_wen<=0; wb_addr and wb_data hold their values.
- Writeback select when MEM/WB loads:
  - jal_in=1: wb_data<=pc_in, zero-extended or truncated to DSIZE.
  - else mem_to_reg_in=1 and the op is a load: wb_data<=dmem_rdata.
  - else: wb_data<=w_data_in.
  - wb_addr<=w_addr_in; wb_wen<=wen_in.
- dmem_ack while dmem_req=0 is ignored.
- Back-to-back memory ops: each op gets its own request starting the cycle after the previous ack. A request is never reissued for a completed op.
- mem_err is cleared only by rst.
- Reset during WAIT: the request drops immediately and the pending op is abandoned.

Optional Feature:
- Macro: PIP_STAGE5_WB_FWD_EN.
- Defined: adds outputs fwd_wen (1), fwd_addr (ASIZE), fwd_data (DSIZE), driven combinationally with the value the MEM/WB register will load this cycle, for EX-stage forwarding. fwd_wen=0 whenever stall=1 or rst=1.
- Undefined: these ports and their logic do not exist; forwarding is taken only from wb_* outputs.

Test Plan:
- ALU op, w_addr_in=3, w_data_in=16'h1234, wen_in=1, no memop -> next edge wb_wen=1, wb_addr=3, wb_data=16'h1234; stall=0 throughout.
- Load from w_data_in=16'hFF20, memory acks 3 cycles after req with dmem_rdata=16'hBEEF -> dmem_addr=8'h20, dmem_we=0, stall=1 for 3 cycles, wb_wen=0 during stall, then wb_data=16'hBEEF.
- Store with rdata2_in=16'h00AA, same-cycle ack -> dmem_we=1, dmem_wdata=16'h00AA, stall never asserted; wb_wen follows wen_in (0).
- jal_in=1, pc_in=16'h0042, w_addr_in=15 -> wb_addr=15, wb_data=16'h0042, no dmem_req.
- Load with no ack, TIMEOUT=15 -> stall high 15 cycles, mem_err=1 on timeout edge, wb_wen=0, next instruction proceeds, mem_err stays 1 until rst.
- rst asserted in WAIT state -> dmem_req=0 and stall=0 immediately; after the edge all outputs are 0 and state is IDLE.

Source files
------------

// File: rtl/pip_stage5.sv
// pip_stage5: memory-access stage plus the MEM/WB pipeline register.
// This stage issues one load or store per instruction to a data memory
// whose latency varies, using a req/ack handshake.
// While an access is outstanding, the stage stalls the upstream pipeline.
// A watchdog drops the instruction and sets a sticky mem_err flag if no
// ack arrives within TIMEOUT cycles.
// Optional build macro: PIP_STAGE5_WB_FWD_EN. It adds the fwd_* outputs,
// which carry the value the MEM/WB register loads this cycle.
module pip_stage5 #(
  parameter int DSIZE   = 16,
  parameter int ASIZE   = 4,
  parameter int ISIZE   = 16,
  parameter int DAWIDTH = 8,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ASIZE-1:0]   w_addr_in,
  input  logic [DSIZE-1:0]   w_data_in,
  input  logic [DSIZE-1:0]   rdata2_in,
  input  logic               mem_write_in,
  input  logic               mem_read_in,
  input  logic               mem_to_reg_in,
  input  logic               wen_in,
  input  logic               jal_in,
  input  logic [ISIZE-1:0]   pc_in,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DAWIDTH-1:0] dmem_addr,
  output logic [DSIZE-1:0]   dmem_wdata,
  input  logic [DSIZE-1:0]   dmem_rdata,
  input  logic               dmem_ack,
  output logic               stall,
  output logic               wb_wen,
  output logic [ASIZE-1:0]   wb_addr,
  output logic [DSIZE-1:0]   wb_data,
`ifdef PIP_STAGE5_WB_FWD_EN
  output logic               fwd_wen,
  output logic [ASIZE-1:0]   fwd_addr,
  output logic [DSIZE-1:0]   fwd_data,
`endif
  output logic               mem_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // The wait counter is 8 bits wide because TIMEOUT can be as large as 255.
  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             wb_wen_q, wb_wen_d;
  logic [ASIZE-1:0] wb_addr_q, wb_addr_d;
  logic [DSIZE-1:0] wb_data_q, wb_data_d;
  logic             mem_err_q, mem_err_d;

  logic             memop_s;
  logic             is_load_s;
  logic             req_s;
  logic             stall_s;
  logic             load_s;     // MEM/WB register captures this instruction
  logic             err_set_s;  // watchdog expired this cycle
  logic [DSIZE-1:0] wb_sel_s;

  // When both load and store are set, the store takes precedence.
  assign memop_s   = mem_read_in | mem_write_in;
  assign is_load_s = mem_read_in & ~mem_write_in;

  assign dmem_addr  = w_data_in[DAWIDTH-1:0];
  assign dmem_wdata = rdata2_in;
  assign dmem_we    = mem_write_in;
  assign dmem_req   = req_s;
  assign stall      = stall_s;

  // Handshake FSM: request, stall, watchdog, and MEM/WB load strobe.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_s     = 1'b0;
    stall_s   = 1'b0;
    load_s    = 1'b0;
    err_set_s = 1'b0;
    if (rst) begin
      state_d = ST_IDLE;
      cnt_d   = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (memop_s) begin
            req_s = 1'b1;
            if (dmem_ack) begin
              load_s = 1'b1;
            end else begin
              stall_s = 1'b1;
              cnt_d   = 8'd1;
              state_d = ST_WAIT;
            end
          end else begin
            load_s = 1'b1;
          end
        end
        ST_WAIT: begin
          req_s = 1'b1;
          if (dmem_ack) begin
            load_s  = 1'b1;
            cnt_d   = 8'd0;
            state_d = ST_IDLE;
          end else if (cnt_q == TIMEOUT_L) begin
            err_set_s = 1'b1;
            cnt_d     = 8'd0;
            state_d   = ST_IDLE;
          end else begin
            stall_s = 1'b1;
            cnt_d   = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  // Writeback source select: link PC, then load data, then the ALU result.
  always_comb begin
    wb_sel_s = w_data_in;
    if (jal_in) begin
      wb_sel_s = DSIZE'(pc_in);
    end else if (mem_to_reg_in && is_load_s) begin
      wb_sel_s = dmem_rdata;
    end else begin
      wb_sel_s = w_data_in;
    end
  end

  // MEM/WB next values: capture on load; otherwise insert a bubble and hold addr/data.
  always_comb begin
    wb_wen_d  = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    mem_err_d = mem_err_q | err_set_s;
    if (load_s) begin
      wb_wen_d  = wen_in;
      wb_addr_d = w_addr_in;
      wb_data_d = wb_sel_s;
    end else begin
      wb_wen_d  = 1'b0;
    end
  end

  // State, counter, MEM/WB and sticky error registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      wb_wen_q  <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wb_wen_q  <= wb_wen_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign wb_wen  = wb_wen_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
  assign mem_err = mem_err_q;

`ifdef PIP_STAGE5_WB_FWD_EN
  // fwd_wen is low during a stall or reset because load_s is low then.
  assign fwd_wen  = wb_wen_d;
  assign fwd_addr = w_addr_in;
  assign fwd_data = wb_sel_s;
`endif

endmodule
